decoder_2to4_hs: RTL and testbench

- Registered 2-to-4 one-hot decoder. It is the inverse of the team's 4-to-2 encoder: it consumes the 2-bit code {a1,a0} and drives y0..y3.
- Adds valid/ready handshakes on both sides and a 2-entry skid buffer, so a stalled consumer never drops a code.
- Adds a saturating counter of delivered decodes.
- Sits between code producers (encoder outputs, control paths) and one-hot select consumers.

---
 rtl/dec_pkg.sv | 14 +
 rtl/decoder_2to4_hs_if.sv | 14 +
 rtl/skid_buf2.sv | 41 ++++
 rtl/decoder_2to4_hs.sv | 30 +++
 tb/tb_decoder_2to4_hs.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/dec_pkg.sv
// dec_pkg: shared code constants, buffer entry layout and one-hot decode helper
package dec_pkg;
  localparam logic [1:0] CODE_Y0 = 2'b00;
  localparam logic [1:0] CODE_Y1 = 2'b01;
  localparam logic [1:0] CODE_Y2 = 2'b10;
  localparam logic [1:0] CODE_Y3 = 2'b11;
  typedef struct packed {
    logic [1:0] code;
    logic       en;
  } entry_t;
  function automatic logic [3:0] onehot4(input logic [1:0] code, input logic en);
    return en ? {code == CODE_Y3, code == CODE_Y2, code == CODE_Y1, code == CODE_Y0} : 4'b0000;
  endfunction
endpackage

// File: rtl/decoder_2to4_hs_if.sv
// decoder_2to4_hs_if: producer/consumer handshake bundle of the 2-to-4 decoder
interface decoder_2to4_hs_if #(parameter int CNT_W = 8);
  logic in_valid, in_ready, a0, a1, en;
  logic out_valid, out_ready, y0, y1, y2, y3;
  logic [CNT_W-1:0] dec_cnt;
  modport master (
    output in_valid, a0, a1, en, out_ready,
    input  in_ready, out_valid, y0, y1, y2, y3, dec_cnt
  );
  modport slave (
    input  in_valid, a0, a1, en, out_ready,
    output in_ready, out_valid, y0, y1, y2, y3, dec_cnt
  );
endinterface

// File: rtl/skid_buf2.sv
// skid_buf2: 2-entry valid/ready FIFO with registered in_ready
module skid_buf2 #(
  parameter int W     = 3,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [W-1:0] mem [2];
  logic         wr_ptr, rd_ptr, push, pop;
  logic [1:0]   occ, occ_nxt;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = occ != 2'd0;
  assign out_data  = mem[rd_ptr];
  assign occ_nxt   = occ + {1'b0, push} - {1'b0, pop};
  // in_ready looks only at next occupancy, so out_ready never reaches it combinationally
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      occ      <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      in_ready <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ      <= occ_nxt;
      in_ready <= occ_nxt < 2'(DEPTH);
    end
endmodule

// File: rtl/decoder_2to4_hs.sv
// decoder_2to4_hs: buffered 2-to-4 one-hot decoder with handshakes and saturating decode count
module decoder_2to4_hs
  import dec_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int DEPTH = 2
) (
  input logic               clk,
  input logic               rst,
  decoder_2to4_hs_if.slave  bus
);
  entry_t head;
  logic   pop;
  skid_buf2 #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   ({bus.a1, bus.a0, bus.en}),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (head)
  );
  assign pop = bus.out_valid & bus.out_ready;
  // y decodes straight from the registered head, gated so an empty buffer shows nothing
  assign {bus.y3, bus.y2, bus.y1, bus.y0} = bus.out_valid ? onehot4(head.code, head.en) : 4'b0000;
  always_ff @(posedge clk or posedge rst)
    if (rst) bus.dec_cnt <= '0;
    else if (pop && head.en && !(&bus.dec_cnt)) bus.dec_cnt <= bus.dec_cnt + CNT_W'(1);
endmodule

// File: tb/tb_decoder_2to4_hs.sv
// tb_decoder_2to4_hs: directed stimulus with scoreboard-driven checking of decoder_2to4_hs
module tb_decoder_2to4_hs;
  import dec_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  decoder_2to4_hs_if #(.CNT_W(8)) bus ();
  decoder_2to4_hs_if #(.CNT_W(2)) sbus ();
  decoder_2to4_hs #(.CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  decoder_2to4_hs #(.CNT_W(2)) dut_sat (.clk(clk), .rst(rst), .bus(sbus));
  int errors = 0;
  int checks = 0;
  logic [4:0] q[$];
  logic [4:0] mon_e;
  logic [7:0] model_cnt = 8'd0;
  logic [1:0] sc [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [3:0] sy [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [7:0] sat_exp [5] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] yv();
    return {4'b0000, bus.y3, bus.y2, bus.y1, bus.y0};
  endfunction
  task automatic push(input logic [1:0] code, input logic en, input logic [3:0] y_exp);
    int n = 0;
    bus.in_valid = 1'b1;
    {bus.a1, bus.a0} = code;
    bus.en = en;
    do @(negedge clk); while (!bus.in_ready && ++n < 20);
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: in_ready stayed 0 for code %b", code);
      bus.in_valid = 1'b0;
      return;
    end
    q.push_back({en, y_exp});
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  // monitor: every negedge compares counter and, on a transfer, the head against the scoreboard
  always @(negedge clk) if (!rst) begin
    chk("dec_cnt", bus.dec_cnt, model_cnt);
    if (!bus.out_valid) chk("idle_y", yv(), 8'h00);
    else if (bus.out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: y=%0h with empty scoreboard", yv());
      end else begin
        mon_e = q.pop_front();
        chk("pop_y", yv(), {4'b0000, mon_e[3:0]});
        if (mon_e[4] && model_cnt != 8'hff) model_cnt++;
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.in_valid = 0; bus.a0 = 0; bus.a1 = 0; bus.en = 0; bus.out_ready = 0;
    sbus.in_valid = 0; sbus.a0 = 0; sbus.a1 = 0; sbus.en = 0; sbus.out_ready = 0;
    #2;
    chk("rst_in_ready", 8'(bus.in_ready), 8'h0);
    chk("rst_out_valid", 8'(bus.out_valid), 8'h0);
    chk("rst_y", yv(), 8'h00);
    chk("rst_cnt", bus.dec_cnt, 8'h00);
    #10 rst = 1'b0;
    #2 chk("rel_in_ready_pre", 8'(bus.in_ready), 8'h0);
    @(posedge clk); #1 chk("rel_in_ready_post", 8'(bus.in_ready), 8'h1);
    // streaming with the consumer always ready
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("model_onehot", {4'b0000, onehot4(sc[i], 1'b1)}, {4'b0000, sy[i]});
      push(sc[i], 1'b1, sy[i]);
      chk("stream_in_ready", 8'(bus.in_ready), 8'h1);
    end
    repeat (2) @(posedge clk);
    #1 chk("stream_cnt", bus.dec_cnt, 8'd4);
    chk("stream_drained", 8'(bus.out_valid), 8'h0);
    // backpressure fills the buffer and holds the head
    bus.out_ready = 1'b0;
    push(2'b11, 1'b1, 4'b1000);
    push(2'b01, 1'b1, 4'b0010);
    chk("bp_in_ready", 8'(bus.in_ready), 8'h0);
    chk("bp_y", yv(), 8'b1000);
    repeat (2) @(posedge clk);
    #1 chk("bp_hold_y", yv(), 8'b1000);
    chk("bp_hold_valid", 8'(bus.out_valid), 8'h1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1 chk("bp_next_y", yv(), 8'b0010);
    @(posedge clk); #1 chk("bp_empty", 8'(bus.out_valid), 8'h0);
    chk("bp_cnt", bus.dec_cnt, 8'd6);
    // disabled decode keeps out_valid but shows no select
    bus.out_ready = 1'b0;
    push(2'b10, 1'b0, 4'b0000);
    chk("dis_valid", 8'(bus.out_valid), 8'h1);
    chk("dis_y", yv(), 8'h00);
    bus.out_ready = 1'b1;
    @(posedge clk); #1 chk("dis_empty", 8'(bus.out_valid), 8'h0);
    chk("dis_cnt", bus.dec_cnt, 8'd6);
    // full buffer: a waiting push only enters after a pop reopens in_ready
    bus.out_ready = 1'b0;
    push(2'b00, 1'b1, 4'b0001);
    push(2'b11, 1'b1, 4'b1000);
    bus.out_ready = 1'b1;
    push(2'b01, 1'b1, 4'b0010);
    repeat (3) @(posedge clk);
    #1 chk("full_cnt", bus.dec_cnt, 8'd9);
    // asynchronous reset with two entries buffered
    bus.out_ready = 1'b0;
    push(2'b01, 1'b1, 4'b0010);
    push(2'b10, 1'b1, 4'b0100);
    @(posedge clk);
    #3 rst = 1'b1;
    q.delete();
    model_cnt = 8'd0;
    #1 chk("arst_valid", 8'(bus.out_valid), 8'h0);
    chk("arst_y", yv(), 8'h00);
    chk("arst_cnt", bus.dec_cnt, 8'h00);
    chk("arst_in_ready", 8'(bus.in_ready), 8'h0);
    #2 rst = 1'b0;
    #1 chk("arst_rel_pre", 8'(bus.in_ready), 8'h0);
    @(posedge clk); #1 chk("arst_rel_post", 8'(bus.in_ready), 8'h1);
    chk("arst_rel_valid", 8'(bus.out_valid), 8'h0);
    // saturation on the CNT_W=2 instance
    sbus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      {sbus.a1, sbus.a0} = sc[i % 4];
      sbus.en = 1'b1;
      chk("sat_in_ready", 8'(sbus.in_ready), 8'h1);
      sbus.in_valid = 1'b1;
      @(posedge clk); #1 sbus.in_valid = 1'b0;
      chk("sat_y", {4'b0000, sbus.y3, sbus.y2, sbus.y1, sbus.y0}, {4'b0000, sy[i % 4]});
      @(posedge clk); #1 chk("sat_cnt", 8'(sbus.dec_cnt), sat_exp[i]);
    end
    chk("sb_empty", 8'(q.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
